// File: rtl/sbox_ghpc_pkg.sv
// +----------------------------------------------------------------------------+
// | Package  : sbox_ghpc_pkg                                                    |
// | Purpose  : Shared constants and nibble functions for the GHPC S-box step-2. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package sbox_ghpc_pkg;

   localparam int         NIBBLE_W    = 4;
   localparam logic [3:0] STEP2_CONST = 4'b1100;

   // Nonlinear core evaluated by the gadget (input already bit-reversed)
   function automatic logic [3:0] step2_g(input logic [3:0] x);
      step2_g = {x[3], x[2], x[1] ^ (x[3] & x[2]), x[0] ^ (x[3] | x[2])};
   endfunction

   function automatic logic [3:0] step2_lin(input logic [3:0] g);
      logic [3:0] t;
      t[0] = g[0];
      t[1] = g[1];
      t[2] = g[2] ^ g[1];
      t[3] = g[3] ^ g[0] ^ g[2];
      step2_lin = {t[0], t[1], t[3], t[2]};
   endfunction

   function automatic logic [3:0] step2_ref(input logic [3:0] x);
      logic [3:0] xr;
      xr        = {x[0], x[1], x[2], x[3]};
      step2_ref = step2_lin(step2_g(xr)) ^ STEP2_CONST;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sbox_ghpc_step2_lane.sv
// +----------------------------------------------------------------------------+
// | Module   : sbox_ghpc_step2_lane                                             |
// | Purpose  : One 4-bit lane: 2-share GHPC gadget, linear layer and constant.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module sbox_ghpc_step2_lane
   import sbox_ghpc_pkg::*;
#(
   parameter int LOW_LATENCY = 0,
   parameter int PIPELINE    = 1,
   parameter int LAT         = 1
) (
   input  logic       clk,
   input  logic [3:0] in0_i,
   input  logic [3:0] in1_i,
   input  logic [3:0] r_i,
   output logic [3:0] out0_o,
   output logic [3:0] out1_o
);

   localparam int c_glat  = (LOW_LATENCY != 0 || PIPELINE < 1) ? 1 : PIPELINE;
   localparam int c_total = (LAT > c_glat) ? LAT : c_glat;
   localparam int c_extra = c_total - 1;

   logic [3:0] w_x0;
   logic [3:0] w_x1;
   logic [3:0] r_tab_q [16];
   logic [3:0] r_x0_q;
   logic [3:0] r_r_q;
   logic [3:0] w_g0;
   logic [3:0] w_g1;
   logic [3:0] w_o0;
   logic [3:0] w_o1;

   assign w_x0 = {in0_i[0], in0_i[1], in0_i[2], in0_i[3]};
   assign w_x1 = {in1_i[0], in1_i[1], in1_i[2], in1_i[3]};

   // Each table entry sees only share 1 and r; share 0 selects after the register
   always_ff @(posedge clk) begin
      for (int v = 0; v < 16; v++) begin
         r_tab_q[v] <= step2_g(4'(v) ^ w_x1) ^ r_i;
      end
      r_x0_q <= w_x0;
      r_r_q  <= r_i;
   end

   assign w_g0 = r_tab_q[r_x0_q];
   assign w_g1 = r_r_q;
   assign w_o0 = step2_lin(w_g0) ^ STEP2_CONST;
   assign w_o1 = step2_lin(w_g1);

   if (c_extra == 0) begin : g_no_pad
      assign out0_o = w_o0;
      assign out1_o = w_o1;
   end else begin : g_pad
      logic [3:0] r_p0_q [c_extra];
      logic [3:0] r_p1_q [c_extra];

      always_ff @(posedge clk) begin
         r_p0_q[0] <= w_o0;
         r_p1_q[0] <= w_o1;
         for (int i = 1; i < c_extra; i++) begin
            r_p0_q[i] <= r_p0_q[i-1];
            r_p1_q[i] <= r_p1_q[i-1];
         end
      end

      assign out0_o = r_p0_q[c_extra-1];
      assign out1_o = r_p1_q[c_extra-1];
   end

endmodule

`default_nettype wire

// File: rtl/sbox_ghpc_step2_lanes.sv
// +----------------------------------------------------------------------------+
// | Module   : sbox_ghpc_step2_lanes                                            |
// | Purpose  : NLANE-wide masked Skinny S-box step-2 with valid line, counter.  |
// |            Macro GHPC_RAND_GATE_EN gates acceptance on fresh randomness.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module sbox_ghpc_step2_lanes
   import sbox_ghpc_pkg::*;
#(
   parameter int NLANE       = 4,
   parameter int LOW_LATENCY = 0,
   parameter int PIPELINE    = 1,
   parameter int LAT         = 1,
   parameter int CNT_W       = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*NLANE-1:0]    in0,
   input  logic [4*NLANE-1:0]    in1,
   input  logic [4*NLANE-1:0]    r,
   input  logic                  r_valid,
   output logic                  out_valid,
   output logic [4*NLANE-1:0]    out0,
   output logic [4*NLANE-1:0]    out1,
   output logic [CNT_W-1:0]      op_count
`ifdef GHPC_RAND_GATE_EN
   ,
   output logic                  rand_used
`endif
);

   localparam logic [CNT_W-1:0] c_cnt_max = '1;

   logic             w_fire;
   logic [LAT-1:0]   r_vline_q;
   logic [LAT-1:0]   w_vline_d;
   logic [CNT_W-1:0] r_cnt_q;
   logic [CNT_W-1:0] w_cnt_d;

`ifdef GHPC_RAND_GATE_EN
   assign in_ready  = r_valid;
   assign rand_used = w_fire;
`else
   logic w_unused_r_valid;
   assign w_unused_r_valid = r_valid;
   assign in_ready         = 1'b1;
`endif

   assign w_fire = in_valid & in_ready;

   for (genvar k = 0; k < NLANE; k++) begin : g_lane
      sbox_ghpc_step2_lane #(
         .LOW_LATENCY (LOW_LATENCY),
         .PIPELINE    (PIPELINE),
         .LAT         (LAT)
      ) u_lane (
         .clk    (clk),
         .in0_i  (in0 [NIBBLE_W*k +: NIBBLE_W]),
         .in1_i  (in1 [NIBBLE_W*k +: NIBBLE_W]),
         .r_i    (r   [NIBBLE_W*k +: NIBBLE_W]),
         .out0_o (out0[NIBBLE_W*k +: NIBBLE_W]),
         .out1_o (out1[NIBBLE_W*k +: NIBBLE_W])
      );
   end

   if (LAT == 1) begin : g_vline_1
      assign w_vline_d = w_fire;
   end else begin : g_vline_n
      assign w_vline_d = {r_vline_q[LAT-2:0], w_fire};
   end

   // Count moves on the same edge that raises out_valid
   always_comb begin
      w_cnt_d = r_cnt_q;
      if (w_vline_d[LAT-1] && (r_cnt_q != c_cnt_max)) begin
         w_cnt_d = r_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vline_q <= '0;
         r_cnt_q   <= '0;
      end else begin
         r_vline_q <= w_vline_d;
         r_cnt_q   <= w_cnt_d;
      end
   end

   assign out_valid = r_vline_q[LAT-1];
   assign op_count  = r_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_sbox_ghpc_step2_lanes.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_sbox_ghpc_step2_lanes                                         |
// | Purpose  : Self-checking bench against an unmasked step-2 reference model.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sbox_ghpc_step2_lanes;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance: defaults (NLANE=4, LAT=1, CNT_W=16)
   logic        rst_n, in_valid, in_ready, r_valid, out_valid;
   logic [15:0] in0, in1, r, out0, out1, op_count;
   // Second instance: one lane, LAT=3, CNT_W=3
   logic        b_rst_n, b_in_valid, b_in_ready, b_r_valid, b_out_valid;
   logic [3:0]  b_in0, b_in1, b_r, b_out0, b_out1;
   logic [2:0]  b_op_count;
`ifdef GHPC_RAND_GATE_EN
   logic        rand_used, b_rand_used;
`endif

   int checks = 0;
   int errors = 0;
   int exp_cnt_a = 0;

   sbox_ghpc_step2_lanes dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in0(in0), .in1(in1), .r(r), .r_valid(r_valid),
      .out_valid(out_valid), .out0(out0), .out1(out1), .op_count(op_count)
`ifdef GHPC_RAND_GATE_EN
      , .rand_used(rand_used)
`endif
   );

   sbox_ghpc_step2_lanes #(.NLANE(1), .LAT(3), .CNT_W(3)) dut_b (
      .clk(clk), .rst_n(b_rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in0(b_in0), .in1(b_in1), .r(b_r), .r_valid(b_r_valid),
      .out_valid(b_out_valid), .out0(b_out0), .out1(b_out1), .op_count(b_op_count)
`ifdef GHPC_RAND_GATE_EN
      , .rand_used(b_rand_used)
`endif
   );

   // Unmasked step-2 written straight from the bit-level rules
   function automatic logic [3:0] ref_step2(input logic [3:0] x);
      int a [4];
      int g [4];
      int t [4];
      logic [3:0] y;
      for (int i = 0; i < 4; i++) a[i] = int'(x[3-i]);
      g[3] = a[3];
      g[2] = a[2];
      g[1] = a[1] ^ (a[3] & a[2]);
      g[0] = a[0] ^ (a[3] | a[2]);
      t[0] = g[0];
      t[1] = g[1];
      t[2] = g[2] ^ g[1];
      t[3] = g[3] ^ g[0] ^ g[2];
      y[0] = t[2][0];
      y[1] = t[3][0];
      y[2] = t[1][0];
      y[3] = t[0][0];
      return y ^ 4'hC;
   endfunction

   function automatic logic [15:0] ref_vec(input logic [15:0] x);
      logic [15:0] v;
      for (int k = 0; k < 4; k++) v[4*k +: 4] = ref_step2(x[4*k +: 4]);
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic [15:0] x);
      in1 = 16'($urandom);
      r   = 16'($urandom);
      in0 = x ^ in1;
   endtask

   task automatic drive_b(input logic [3:0] x);
      b_in1 = 4'($urandom);
      b_r   = 4'($urandom);
      b_in0 = x ^ b_in1;
   endtask

   task automatic test_reset();
      logic [15:0] xa;
      rst_n = 1'b0; b_rst_n = 1'b0; in_valid = 1'b1; b_in_valid = 1'b1;
      drive_a(16'h1234); drive_b(4'h3);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks += 3;
         if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
         if (op_count !== 16'd0) begin errors++; $display("FAIL reset_op_count: got %0d want 0", op_count); end
         if (b_out_valid !== 1'b0 || b_op_count !== 3'd0) begin
            errors++; $display("FAIL reset_b: got valid %b cnt %0d want 0 0", b_out_valid, b_op_count);
         end
      end
      rst_n = 1'b1; b_rst_n = 1'b1; b_in_valid = 1'b0;
      xa = 16'hA5C3;
      drive_a(xa);
      tick();
      exp_cnt_a = 1;
      checks += 3;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL first_out_valid: got %b want 1", out_valid); end
      if (op_count !== 16'd1) begin errors++; $display("FAIL first_op_count: got %0d want 1", op_count); end
      if ((out0 ^ out1) !== ref_vec(xa)) begin
         errors++; $display("FAIL first_data: got %h want %h", out0 ^ out1, ref_vec(xa));
      end
      in_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL after_first_idle: got %b want 0", out_valid); end
   endtask

   task automatic test_exhaustive();
      logic [15:0] x;
      for (int i = 0; i < 16; i++) begin
         for (int k = 0; k < 4; k++) x[4*k +: 4] = 4'((i + 5*k) % 16);
         in_valid = 1'b1;
         drive_a(x);
         tick();
         exp_cnt_a++;
         checks += 2;
         if (out_valid !== 1'b1) begin errors++; $display("FAIL exh_valid[%0d]: got %b want 1", i, out_valid); end
         if ((out0 ^ out1) !== ref_vec(x)) begin
            errors++; $display("FAIL exh_data[%0d]: got %h want %h", i, out0 ^ out1, ref_vec(x));
         end
      end
      in_valid = 1'b0;
      tick();
      checks += 2;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL exh_tail_valid: got %b want 0", out_valid); end
      if (op_count !== 16'(exp_cnt_a)) begin
         errors++; $display("FAIL exh_op_count: got %0d want %0d", op_count, exp_cnt_a);
      end
   endtask

   task automatic test_mask_independence();
      logic [15:0] first;
      logic        varied;
      first = '0; varied = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         drive_a(16'h5555);
         tick();
         exp_cnt_a++;
         checks++;
         if ((out0 ^ out1) !== ref_vec(16'h5555)) begin
            errors++; $display("FAIL mask_data[%0d]: got %h want %h", i, out0 ^ out1, ref_vec(16'h5555));
         end
         if (i == 0) first = out0;
         else if (out0 !== first) varied = 1'b1;
      end
      in_valid = 1'b0;
      tick();
      checks++;
      if (varied !== 1'b1) begin errors++; $display("FAIL mask_share0_varies: got %b want 1", varied); end
   endtask

   task automatic test_ready();
`ifdef GHPC_RAND_GATE_EN
      int exp_ready [4];
      int pulses;
      exp_ready = '{1, 0, 0, 1};
      pulses = 0;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         r_valid = exp_ready[i][0];
         drive_a(16'h0F0F);
         #1;
         checks += 2;
         if (in_ready !== exp_ready[i][0]) begin
            errors++; $display("FAIL gate_in_ready[%0d]: got %b want %0d", i, in_ready, exp_ready[i]);
         end
         if (rand_used !== exp_ready[i][0]) begin
            errors++; $display("FAIL gate_rand_used[%0d]: got %b want %0d", i, rand_used, exp_ready[i]);
         end
         tick();
         if (out_valid === 1'b1) pulses++;
      end
      in_valid = 1'b0; r_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (out_valid === 1'b1) pulses++;
      end
      exp_cnt_a += 2;
      checks++;
      if (pulses != 2) begin errors++; $display("FAIL gate_pulses: got %0d want 2", pulses); end
`else
      r_valid = 1'b0;
      in_valid = 1'b1;
      drive_a(16'h0F0F);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_tied: got %b want 1", in_ready); end
      tick();
      exp_cnt_a++;
      checks += 2;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL ready_accept: got %b want 1", out_valid); end
      if ((out0 ^ out1) !== ref_vec(16'h0F0F)) begin
         errors++; $display("FAIL ready_data: got %h want %h", out0 ^ out1, ref_vec(16'h0F0F));
      end
      in_valid = 1'b0; r_valid = 1'b1;
      tick();
`endif
   endtask

   task automatic test_reset_mid_flight();
      int vin  [10];
      int rst  [10];
      int expv [10];
      int expc [10];
      vin  = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 0};
      rst  = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
      expv = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
      expc = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
      for (int j = 0; j < 10; j++) begin
         b_in_valid = vin[j][0];
         b_rst_n    = rst[j][0];
         drive_b(4'h9);
         tick();
         checks += 2;
         if (b_out_valid !== expv[j][0]) begin
            errors++; $display("FAIL midrst_valid[%0d]: got %b want %0d", j, b_out_valid, expv[j]);
         end
         if (b_op_count !== 3'(expc[j])) begin
            errors++; $display("FAIL midrst_count[%0d]: got %0d want %0d", j, b_op_count, expc[j]);
         end
      end
      b_rst_n = 1'b1; b_in_valid = 1'b0;
   endtask

   task automatic test_saturation();
      logic [3:0] q [$];
      logic [3:0] x, xe;
      int done;
      int expc;
      for (int j = 1; j <= 14; j++) begin
         b_in_valid = (j <= 10);
         x = 4'($urandom);
         drive_b(x);
         if (j <= 10) q.push_back(x);
         tick();
         done = (j >= 3) ? ((j - 2 > 10) ? 10 : j - 2) : 0;
         expc = (done > 7) ? 7 : done;
         checks += 2;
         if (b_out_valid !== ((j >= 3) && (j <= 12))) begin
            errors++; $display("FAIL sat_valid[%0d]: got %b", j, b_out_valid);
         end
         if (b_op_count !== 3'(expc)) begin
            errors++; $display("FAIL sat_count[%0d]: got %0d want %0d", j, b_op_count, expc);
         end
         if (j >= 3 && j <= 12 && q.size() > 0) begin
            xe = q.pop_front();
            checks++;
            if ((b_out0 ^ b_out1) !== ref_step2(xe)) begin
               errors++; $display("FAIL sat_data[%0d]: got %h want %h", j, b_out0 ^ b_out1, ref_step2(xe));
            end
         end
      end
      b_in_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; r_valid = 1'b1; in0 = '0; in1 = '0; r = '0;
      b_rst_n = 1'b0; b_in_valid = 1'b0; b_r_valid = 1'b1; b_in0 = '0; b_in1 = '0; b_r = '0;
      test_reset();
      test_exhaustive();
      test_mask_independence();
      test_ready();
      test_reset_mid_flight();
      test_saturation();
      checks++;
      if (op_count !== 16'(exp_cnt_a)) begin
         errors++; $display("FAIL final_op_count: got %0d want %0d", op_count, exp_cnt_a);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
